// File: rtl/segre_mem_arbiter.sv
// ---------------------------------------------------------------------------
// segre_mem_arbiter
//
// Shares the single memory port between the instruction-fetch requester and
// the data (load/store) requester. A grant is given only from IDLE. It
// latches the winner's address, write enable, write data and byte enables.
// The latched values drive the memory port until mem_ready_i arrives. At that
// point the winner gets a one-cycle ready pulse. When both requesters ask at
// once, the grant alternates between them.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   if_req_i/addr_i     fetch request (held until if_ready_o)
//   if_ready_o/rdata_o  fetch completion pulse and returned word
//   d_req_i/we_i/addr_i/wdata_i/be_i  data request (held until d_ready_o)
//   d_ready_o/rdata_o   data completion pulse and load data
//   mem_rd_o/wr_o       memory read / write strobes
//   mem_addr_o/wdata_o/be_o  latched transaction fields
//   mem_rdata_i/ready_i memory read data and completion
// ---------------------------------------------------------------------------
module segre_mem_arbiter #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   if_req_i,
    input  logic [ADDR_SIZE-1:0]   if_addr_i,
    output logic                   if_ready_o,
    output logic [WORD_SIZE-1:0]   if_rdata_o,
    input  logic                   d_req_i,
    input  logic                   d_we_i,
    input  logic [ADDR_SIZE-1:0]   d_addr_i,
    input  logic [WORD_SIZE-1:0]   d_wdata_i,
    input  logic [WORD_SIZE/8-1:0] d_be_i,
    output logic                   d_ready_o,
    output logic [WORD_SIZE-1:0]   d_rdata_o,
    output logic                   mem_rd_o,
    output logic                   mem_wr_o,
    output logic [ADDR_SIZE-1:0]   mem_addr_o,
    output logic [WORD_SIZE-1:0]   mem_wdata_o,
    output logic [WORD_SIZE/8-1:0] mem_be_o,
    input  logic [WORD_SIZE-1:0]   mem_rdata_i,
    input  logic                   mem_ready_i
);

    localparam int BE_SIZE = WORD_SIZE / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_e;

    state_e                 state_r;
    state_e                 state_next_s;
    logic                   last_d_r;
    logic                   grant_if_s;
    logic                   grant_d_s;
    logic                   we_r;
    logic [ADDR_SIZE-1:0]   addr_r;
    logic [WORD_SIZE-1:0]   wdata_r;
    logic [BE_SIZE-1:0]     be_r;

    // Next-state and grant decision; requests are only looked at in IDLE.
    always_comb begin
        state_next_s = state_r;
        grant_if_s   = 1'b0;
        grant_d_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (if_req_i && d_req_i) begin
                    // Tie: whoever did not win last time gets the port.
                    if (last_d_r) begin
                        state_next_s = BUSY_IF;
                        grant_if_s   = 1'b1;
                    end else begin
                        state_next_s = BUSY_D;
                        grant_d_s    = 1'b1;
                    end
                end else if (if_req_i) begin
                    state_next_s = BUSY_IF;
                    grant_if_s   = 1'b1;
                end else if (d_req_i) begin
                    state_next_s = BUSY_D;
                    grant_d_s    = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, fairness bit and latched transaction fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            last_d_r <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= {ADDR_SIZE{1'b0}};
            wdata_r  <= {WORD_SIZE{1'b0}};
            be_r     <= {BE_SIZE{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (grant_if_s) begin
                // Fetches are full-word reads; write data is left untouched.
                last_d_r <= 1'b0;
                we_r     <= 1'b0;
                addr_r   <= if_addr_i;
                be_r     <= {BE_SIZE{1'b1}};
            end else if (grant_d_s) begin
                last_d_r <= 1'b1;
                we_r     <= d_we_i;
                addr_r   <= d_addr_i;
                wdata_r  <= d_wdata_i;
                be_r     <= d_be_i;
            end else begin
                last_d_r <= last_d_r;
            end
        end
    end

    // Strobes and completion pulses; reset suppresses a coincident ready.
    always_comb begin
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        if_ready_o = 1'b0;
        d_ready_o  = 1'b0;
        case (state_r)
            IDLE: begin
                mem_rd_o = 1'b0;
            end
            BUSY_IF: begin
                mem_rd_o   = 1'b1;
                if_ready_o = mem_ready_i & ~rst_i;
            end
            BUSY_D: begin
                mem_rd_o  = ~we_r;
                mem_wr_o  = we_r;
                d_ready_o = mem_ready_i & ~rst_i;
            end
            default: begin
                mem_rd_o = 1'b0;
            end
        endcase
    end

    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;
    assign mem_be_o    = be_r;
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Scoreboard bench for segre_mem_arbiter. A reference model is evaluated at
// each rising edge. When it grants, it pushes the expected response. A
// negedge monitor compares the memory port every cycle. It also pops the
// expected response whenever the DUT pulses a ready.
module tb_segre_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ready_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_ready_o;
    logic [31:0] d_rdata_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    always #5 clk = ~clk;

    segre_mem_arbiter #(.ADDR_SIZE(32), .WORD_SIZE(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
        .d_ready_o(d_ready_o), .d_rdata_o(d_rdata_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    // Memory contents as a fixed function of the address it is presented with.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_00C3;
    endfunction
    assign mem_rdata_i = rd_fn(mem_addr_o);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner 0 = none, 1 = fetch, 2 = data.
    int          owner  = 0;
    bit          last_d = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [3:0]  m_be   = 4'h0;
    bit          m_we   = 1'b0;
    int          lat    = 0;
    logic [31:0] exp_if_q[$];
    logic [32:0] exp_d_q[$];     // bit 32 set: store, read data not checked

    // Stimulus knobs.
    int p_if = 0, p_d = 0, p_spur = 0, p_rst = 0, p_drop = 0;
    int lat_max = 3, lat_fixed = -1;
    bit force_rst = 1'b0;
    bit mon_en = 1'b0;
    int n_if_rdy = 0, n_d_rdy = 0;

    task automatic new_if();
        if_req_i  = 1'b1;
        if_addr_i = $urandom() & 32'hFFFF_FFFC;
    endtask

    task automatic new_d();
        d_req_i   = 1'b1;
        d_we_i    = 1'($urandom_range(0, 1));
        d_addr_i  = $urandom() & 32'hFFFF_FFFC;
        d_wdata_i = $urandom();
        d_be_i    = 4'($urandom_range(0, 15));
    endtask

    // One clock: update the model with what the DUT just sampled, then redrive.
    task automatic step();
        bit done_if;
        bit done_d;
        int win;
        @(posedge clk);
        done_if = 1'b0;
        done_d  = 1'b0;
        win     = 0;
        if (rst_i) begin
            if (owner == 1) void'(exp_if_q.pop_back());
            if (owner == 2) void'(exp_d_q.pop_back());
            owner = 0; last_d = 1'b0;
            m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0; m_we = 1'b0;
        end else if (owner != 0) begin
            if (mem_ready_i) begin
                done_if = (owner == 1);
                done_d  = (owner == 2);
                owner   = 0;
            end
        end else begin
            if (if_req_i && d_req_i) win = last_d ? 1 : 2;
            else if (if_req_i)       win = 1;
            else if (d_req_i)        win = 2;
            if (win == 1) begin
                owner = 1; last_d = 1'b0; m_addr = if_addr_i; m_we = 1'b0; m_be = 4'hF;
                exp_if_q.push_back(rd_fn(if_addr_i));
            end else if (win == 2) begin
                owner = 2; last_d = 1'b1; m_addr = d_addr_i; m_we = d_we_i;
                m_wdata = d_wdata_i; m_be = d_be_i;
                exp_d_q.push_back({d_we_i, rd_fn(d_addr_i)});
            end
            if (win != 0) lat = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, lat_max);
        end
        #1;
        if (done_if) begin
            if ($urandom_range(0, 99) < p_if) new_if(); else if_req_i = 1'b0;
        end else if (!if_req_i && owner != 1) begin
            if ($urandom_range(0, 99) < p_if) new_if();
        end else if (if_req_i && owner == 1 && $urandom_range(0, 99) < p_drop) begin
            if_req_i = 1'b0;
        end
        if (done_d) begin
            if ($urandom_range(0, 99) < p_d) new_d(); else d_req_i = 1'b0;
        end else if (!d_req_i && owner != 2) begin
            if ($urandom_range(0, 99) < p_d) new_d();
        end else if (d_req_i && owner == 2 && $urandom_range(0, 99) < p_drop) begin
            d_req_i = 1'b0;
        end
        if (owner != 0) begin
            mem_ready_i = (lat == 0);
            if (lat > 0) lat--;
        end else begin
            mem_ready_i = ($urandom_range(0, 99) < p_spur);
        end
        rst_i = force_rst || ($urandom_range(0, 99) < p_rst);
    endtask

    task automatic do_reset();
        force_rst = 1'b1;
        step();
        force_rst = 1'b0;
        step();
    endtask

    // Monitor: memory port every cycle, scoreboard pop on each ready pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] e_if;
            logic [32:0] e_d;
            chk("mem_rd", mem_rd_o, (owner == 1) || (owner == 2 && !m_we));
            chk("mem_wr", mem_wr_o, (owner == 2 && m_we));
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_be", mem_be_o, m_be);
            if (owner == 2 && m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
            chk("if_ready", if_ready_o, (owner == 1) && mem_ready_i && !rst_i);
            chk("d_ready", d_ready_o, (owner == 2) && mem_ready_i && !rst_i);
            if (if_ready_o === 1'b1) begin
                n_if_rdy++;
                if (exp_if_q.size() == 0) begin
                    chk("if_rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e_if = exp_if_q.pop_front();
                    chk("if_rdata", if_rdata_o, e_if);
                end
            end
            if (d_ready_o === 1'b1) begin
                n_d_rdy++;
                if (exp_d_q.size() == 0) begin
                    chk("d_rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e_d = exp_d_q.pop_front();
                    if (!e_d[32]) chk("d_rdata", d_rdata_o, e_d[31:0]);
                end
            end
        end
    end

    task automatic rst_mid(input int l);
        do_reset();
        p_if = 0; p_d = 0; p_spur = 0; lat_fixed = l;
        if_req_i = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h80; d_be_i = 4'hF;
        step();                      // grant to data
        force_rst = 1'b1;
        step();                      // reset driven while busy
        force_rst = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h500;
        lat_fixed = 1;
        step();                      // reset applied; both requests now pending
        repeat (8) step();
    endtask

    int c_if, c_d;

    initial begin
        rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
        d_be_i = 4'h0; mem_ready_i = 1'b0;
        force_rst = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        force_rst = 1'b0;
        step();

        // Fetch only: address 0x100, three strobe cycles.
        lat_fixed = 2;
        if_req_i = 1'b1; if_addr_i = 32'h100;
        repeat (8) step();

        // Store with partial byte enables.
        lat_fixed = 1;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h40;
        d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011;
        repeat (6) step();

        // Fairness from reset: data wins first tie, then strict alternation.
        do_reset();
        p_if = 100; p_d = 100; lat_fixed = 0;
        if_req_i = 1'b1; if_addr_i = 32'h300;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h2000; d_be_i = 4'hF;
        c_if = n_if_rdy; c_d = n_d_rdy;
        repeat (40) step();
        chk("fair_if_count", 64'(n_if_rdy - c_if), 64'd10);
        chk("fair_d_count", 64'(n_d_rdy - c_d), 64'd10);

        // Reset in BUSY_D with memory silent, then with a coincident ready.
        rst_mid(5);
        rst_mid(1);

        // Spurious completion in IDLE with no requests.
        p_if = 0; p_d = 0; if_req_i = 1'b0; d_req_i = 1'b0;
        repeat (4) step();
        p_spur = 100;
        c_if = n_if_rdy; c_d = n_d_rdy;
        repeat (6) step();
        chk("spurious_rdy", 64'((n_if_rdy - c_if) + (n_d_rdy - c_d)), 64'd0);

        // Random traffic with drops, resets and spurious completions.
        p_if = 60; p_d = 60; p_spur = 30; p_rst = 2; p_drop = 10;
        lat_fixed = -1; lat_max = 3;
        repeat (3000) step();

        // Drain and confirm every granted access was answered.
        p_if = 0; p_d = 0; p_rst = 0; p_drop = 0; p_spur = 0; lat_fixed = 0;
        repeat (12) step();
        chk("if_q_empty", 64'(exp_if_q.size()), 64'd0);
        chk("d_q_empty", 64'(exp_d_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
